// File: rtl/psum_pkg.sv
// Shared types and default widths for the partial-sum accumulation sequencer.
//   StIdle..StFin : sequencer states
//   DEF_*         : default widths; the top level exposes these as parameters
package psum_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 24;
  localparam int unsigned DEF_PROD_WIDTH = 16;
  localparam int unsigned DEF_DEPTH      = 32;
  localparam int unsigned DEF_PASS_W     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFirst,
    StPref,
    StAcc,
    StLastDirect,
    StFin
  } state_t;

endpackage

// File: rtl/psum_accumulator_sat_add.sv
// Signed saturating adder: DATA_WIDTH partial sum plus a sign-extended PROD_WIDTH product.
//   i_psum : partial sum (two's complement)
//   i_prod : product (two's complement)
//   o_sum  : sum, clamped to the DATA_WIDTH signed range
//   o_sat  : high when the clamp was applied
module psum_sat_add #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned PROD_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_psum,
  input  logic [PROD_WIDTH-1:0] i_prod,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_sat
);

  // One guard bit is enough to catch overflow of a single addition.
  logic [DATA_WIDTH:0] w_wide;

  assign w_wide = {i_psum[DATA_WIDTH-1], i_psum}
                + {{(DATA_WIDTH + 1 - PROD_WIDTH){i_prod[PROD_WIDTH-1]}}, i_prod};

  always_comb begin
    o_sat = 1'b0;
    o_sum = w_wide[DATA_WIDTH-1:0];
    // Guard bit and sign bit disagree: result left the representable range.
    if (w_wide[DATA_WIDTH] != w_wide[DATA_WIDTH-1]) begin
      o_sat = 1'b1;
      o_sum = w_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH - 1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulation sequencer in front of a per-PE partial-sum FIFO. Over num_pass passes of
// num_pos positions it adds each PE product to the stored partial sum; pass 0 writes
// products directly, the last pass streams final sums to the output drain.
//   clk, rst_n             : clock, asynchronous active-low reset
//   i_start                : job start pulse (ignored while busy)
//   i_num_pos, i_num_pass  : job geometry, latched on start
//   i_prod_in/_valid       : product stream, o_prod_ready accepts
//   i_fifo_rd_data         : FIFO head, valid one cycle after o_fifo_read
//   o_fifo_read/_write     : FIFO pop / push, o_fifo_wdata is the pushed value
//   o_out_data/_valid      : final sums, held until i_out_ready
//   o_busy, o_done         : job in progress / one-cycle completion pulse
//   o_sat_flag             : sticky saturation indicator, cleared by start
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned PASS_W     = DEF_PASS_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [$clog2(DEPTH+1)-1:0]   i_num_pos,
  input  logic [PASS_W-1:0]            i_num_pass,
  input  logic [PROD_WIDTH-1:0]        i_prod_in,
  input  logic                         i_prod_valid,
  output logic                         o_prod_ready,
  input  logic [DATA_WIDTH-1:0]        i_fifo_rd_data,
  output logic                         o_fifo_read,
  output logic                         o_fifo_write,
  output logic [DATA_WIDTH-1:0]        o_fifo_wdata,
  output logic [DATA_WIDTH-1:0]        o_out_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_sat_flag
);

  localparam int unsigned POS_W = $clog2(DEPTH + 1);

  state_t                r_state, w_state_d;
  logic [POS_W-1:0]      r_num_pos, w_num_pos_d, r_pos_cnt, w_pos_cnt_d;
  logic [PASS_W-1:0]     r_num_pass, w_num_pass_d, r_pass_cnt, w_pass_cnt_d;
  logic [DATA_WIDTH-1:0] r_psum, w_psum_op, w_prod_sext, w_sum;
  logic [DATA_WIDTH-1:0] r_out_data, w_load_val, w_fifo_wdata;
  logic                  r_psum_vld, w_psum_vld_d, r_psum_fresh;
  logic                  r_out_valid, r_done, w_done_d, r_sat, w_sat_d, w_sat_add;
  logic                  w_last_pos, w_last_pass, w_out_free, w_hs, w_prod_ready;
  logic                  w_fifo_read, w_fifo_write, w_load_out;

  assign w_prod_sext = {{(DATA_WIDTH - PROD_WIDTH){i_prod_in[PROD_WIDTH-1]}}, i_prod_in};
  assign w_last_pos  = (r_pos_cnt == r_num_pos - POS_W'(1));
  assign w_last_pass = (r_pass_cnt == r_num_pass - PASS_W'(1));
  // Output register can take a new beat this cycle.
  assign w_out_free  = !r_out_valid || i_out_ready;

  // The FIFO head is only presented for the cycle after the pop; hold a copy so a stalled
  // accumulation still sees it.
  assign w_psum_op = r_psum_fresh ? i_fifo_rd_data : r_psum;

  psum_sat_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .PROD_WIDTH (PROD_WIDTH)
  ) u_sat_add (
    .i_psum (w_psum_op),
    .i_prod (i_prod_in),
    .o_sum  (w_sum),
    .o_sat  (w_sat_add)
  );

  // Kept separate from the main next-state logic so the handshake has no feedback loop.
  always_comb begin
    w_prod_ready = 1'b0;
    unique case (r_state)
      StFirst:      w_prod_ready = 1'b1;
      StAcc:        w_prod_ready = r_psum_vld && (!w_last_pass || w_out_free);
      StLastDirect: w_prod_ready = w_out_free;
      default:      w_prod_ready = 1'b0;
    endcase
  end

  assign w_hs = i_prod_valid && w_prod_ready;

  always_comb begin
    w_state_d    = r_state;
    w_num_pos_d  = r_num_pos;
    w_num_pass_d = r_num_pass;
    w_pos_cnt_d  = r_pos_cnt;
    w_pass_cnt_d = r_pass_cnt;
    w_sat_d      = r_sat;
    w_done_d     = 1'b0;
    w_fifo_read  = 1'b0;
    w_fifo_write = 1'b0;
    w_fifo_wdata = '0;
    w_load_out   = 1'b0;
    w_load_val   = w_prod_sext;
    w_psum_vld_d = r_psum_vld;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_num_pos_d  = i_num_pos;
          w_num_pass_d = i_num_pass;
          w_pos_cnt_d  = '0;
          w_pass_cnt_d = '0;
          w_sat_d      = 1'b0;
          if (i_num_pos == '0 || i_num_pass == '0) begin
            w_state_d = StFin;
          end else if (i_num_pass == PASS_W'(1)) begin
            w_state_d = StLastDirect;
          end else begin
            w_state_d = StFirst;
          end
        end
      end
      StFirst: begin
        if (w_hs) begin
          w_fifo_write = 1'b1;
          w_fifo_wdata = w_prod_sext;
          if (w_last_pos) begin
            w_pos_cnt_d  = '0;
            w_pass_cnt_d = PASS_W'(1);
            w_state_d    = StPref;
          end else begin
            w_pos_cnt_d = r_pos_cnt + POS_W'(1);
          end
        end
      end
      StPref: begin
        w_fifo_read = 1'b1;
        w_pos_cnt_d = '0;
        w_state_d   = StAcc;
      end
      StAcc: begin
        if (w_hs) begin
          w_sat_d = r_sat | w_sat_add;
          if (w_last_pass) begin
            w_load_out = 1'b1;
            w_load_val = w_sum;
          end else begin
            w_fifo_write = 1'b1;
            w_fifo_wdata = w_sum;
          end
          // Prefetch the next partial sum so the following product is accepted next cycle.
          if (!w_last_pos) begin
            w_fifo_read = 1'b1;
            w_pos_cnt_d = r_pos_cnt + POS_W'(1);
          end else begin
            w_pos_cnt_d = '0;
            if (w_last_pass) begin
              w_state_d = StFin;
            end else begin
              w_pass_cnt_d = r_pass_cnt + PASS_W'(1);
              w_state_d    = StPref;
            end
          end
        end
      end
      StLastDirect: begin
        if (w_hs) begin
          w_load_out = 1'b1;
          if (w_last_pos) begin
            w_pos_cnt_d = '0;
            w_state_d   = StFin;
          end else begin
            w_pos_cnt_d = r_pos_cnt + POS_W'(1);
          end
        end
      end
      StFin: begin
        if (w_out_free) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_fifo_read) begin
      w_psum_vld_d = 1'b1;
    end else if (r_state == StAcc && w_hs) begin
      w_psum_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_num_pos  <= '0;
      r_num_pass <= '0;
      r_pos_cnt  <= '0;
      r_pass_cnt <= '0;
      r_sat      <= 1'b0;
      r_done     <= 1'b0;
      r_psum_vld <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_num_pos  <= w_num_pos_d;
      r_num_pass <= w_num_pass_d;
      r_pos_cnt  <= w_pos_cnt_d;
      r_pass_cnt <= w_pass_cnt_d;
      r_sat      <= w_sat_d;
      r_done     <= w_done_d;
      r_psum_vld <= w_psum_vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum       <= '0;
      r_psum_fresh <= 1'b0;
    end else begin
      r_psum_fresh <= w_fifo_read;
      if (r_psum_fresh) begin
        r_psum <= i_fifo_rd_data;
      end
    end
  end

  // A new beat wins over the drain clearing valid in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      r_out_data  <= w_load_val;
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_prod_ready = w_prod_ready;
  assign o_fifo_read  = w_fifo_read;
  assign o_fifo_write = w_fifo_write;
  assign o_fifo_wdata = w_fifo_wdata;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;
  assign o_sat_flag   = r_sat;

endmodule
